// File: rtl/ifetch_utlb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_utlb_pkg
// Description : Shared constants, FSM encoding and micro-TLB entry layout for
//               the instruction-fetch micro-TLB stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_utlb_pkg;

    // ExcCode values reported by the fetch stage
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_TLBL = 5'h02;

    // CP0 Status bit positions
    localparam int STATUS_UM  = 4;
    localparam int STATUS_EXL = 1;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REQ    = 2'd2
    } fetch_state_e;

    // One micro-TLB entry payload (valid bit is kept separately)
    typedef struct packed {
        logic [19:0] vpn;
        logic [19:0] pfn;
        logic        miss;
        logic        invalid;
        logic [2:0]  cattr;
    } utlb_entry_t;

    // kseg0/kseg1 bypass translation
    function automatic logic is_unmapped(input logic [31:0] va);
        return va[31:30] == 2'b10;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_utlb_array.sv
`default_nettype none
// ============================================================================
// Module      : utlb_array
// Description : Fully associative micro-TLB storage with VPN match, lowest-
//               free-slot fill and round-robin replacement.
// Revision    : 1.0 - initial release
// ============================================================================
module utlb_array
    import ifetch_utlb_pkg::*;
#(
    parameter  int ENTRIES = 4,
    localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [19:0]       i_vpn,
    output logic              o_hit,
    output utlb_entry_t       o_hit_entry,
    input  logic              i_fill,
    input  utlb_entry_t       i_fill_entry,
    output logic [IDX_W-1:0]  o_fill_idx,
    input  logic              i_clear,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output utlb_entry_t       o_rd_entry
);

    logic [ENTRIES-1:0] r_valid;
    utlb_entry_t        r_entry [ENTRIES];
    logic [IDX_W-1:0]   r_rr;
    logic               w_has_free;
    logic [IDX_W-1:0]   w_free_idx;

    // Associative match; fills only ever happen on a miss so matches are unique
    always_comb begin
        o_hit       = 1'b0;
        o_hit_entry = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_entry[i].vpn == i_vpn)) begin
                o_hit       = 1'b1;
                o_hit_entry = r_entry[i];
            end
        end
    end

    // Lowest-index invalid slot (scan downwards so the lowest one wins)
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign o_fill_idx = w_has_free ? w_free_idx : r_rr;
    assign o_rd_entry = r_entry[i_rd_idx];

    // Valid bits and replacement pointer; a flush overrides a same-cycle fill
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
            r_rr    <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_fill) begin
            r_valid[o_fill_idx] <= 1'b1;
            if (!w_has_free) begin
                r_rr <= (r_rr == IDX_W'(ENTRIES - 1)) ? '0 : r_rr + 1'b1;
            end
        end
    end

    // Payload is written even under a flush so the in-flight REQ still sees it
    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_entry[o_fill_idx] <= i_fill_entry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_utlb.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_utlb
// Description : Instruction-fetch address stage: micro-TLB lookup, main-TLB
//               refill walk, memory request issue and fetch exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_utlb
    import ifetch_utlb_pkg::*;
#(
    parameter int UTLB_ENTRIES = 4,
    parameter int PERF_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  valid_i,
    input  logic [31:0]           pc_i,
    input  logic                  ready_i,
    output logic                  ready_o,
    output logic                  inst_req,
    output logic                  inst_cache,
    output logic [31:0]           inst_addr,
    input  logic                  inst_addr_ok,
    output logic [31:0]           tlb_vaddr,
    input  logic [31:0]           tlb_paddr,
    input  logic                  tlb_miss,
    input  logic                  tlb_invalid,
    input  logic [2:0]            tlb_cattr,
    input  logic                  tlb_write,
    input  logic                  commit_i,
    input  logic [31:0]           status,
    input  logic [2:0]            config_k0,
    output logic                  valid_o,
    output logic [31:0]           pc_o,
    output logic                  cancelled_o,
    output logic                  exc_o,
    output logic                  exc_miss_o,
    output logic [4:0]            exccode_o,
    output logic                  ok_to_branch,
    output logic [PERF_WIDTH-1:0] perf_utlb_miss,
    output logic [PERF_WIDTH-1:0] perf_waitreq
);

    localparam int IDX_W = (UTLB_ENTRIES > 1) ? $clog2(UTLB_ENTRIES) : 1;

    fetch_state_e     r_state;
    fetch_state_e     w_next;
    logic [31:0]      r_pc_save;
    logic [IDX_W-1:0] r_fill_idx;
    logic [IDX_W-1:0] w_fill_idx;
    logic             w_hit;
    utlb_entry_t      w_hit_entry;
    utlb_entry_t      w_rd_entry;
    utlb_entry_t      w_fill_entry;
    logic [31:0]      w_cur_pc;
    logic             w_unmapped;
    logic             w_user;
    logic             w_adel;
    logic             w_can_req;
    logic             w_tlb_exc;
    logic             w_sel_miss;
    logic             w_exc;
    logic             w_unused;

    // In LOOKUP/REQ the PC being translated is the one captured in IDLE
    assign w_cur_pc   = (r_state == ST_IDLE) ? pc_i : r_pc_save;
    assign w_unmapped = is_unmapped(pc_i);
    assign w_user     = status[STATUS_UM] && !status[STATUS_EXL];
    assign w_adel     = (w_cur_pc[1:0] != 2'b00) || (w_cur_pc[31] && w_user);
    assign tlb_vaddr  = r_pc_save;
    assign ok_to_branch = (r_state == ST_IDLE);

    assign w_fill_entry = '{vpn: r_pc_save[31:12], pfn: tlb_paddr[31:12],
                            miss: tlb_miss, invalid: tlb_invalid, cattr: tlb_cattr};

    utlb_array #(
        .ENTRIES (UTLB_ENTRIES)
    ) u_array (
        .clk          (clk),
        .resetn       (resetn),
        .i_vpn        (pc_i[31:12]),
        .o_hit        (w_hit),
        .o_hit_entry  (w_hit_entry),
        .i_fill       (r_state == ST_LOOKUP),
        .i_fill_entry (w_fill_entry),
        .o_fill_idx   (w_fill_idx),
        .i_clear      (tlb_write || commit_i),
        .i_rd_idx     (r_fill_idx),
        .o_rd_entry   (w_rd_entry)
    );

    // Next state plus translated address / cache attribute / TLB-exception source
    always_comb begin
        w_next     = r_state;
        w_can_req  = 1'b0;
        w_tlb_exc  = 1'b0;
        w_sel_miss = 1'b0;
        inst_addr  = '0;
        inst_cache = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_unmapped) begin
                    w_can_req  = 1'b1;
                    inst_addr  = {3'b000, pc_i[28:0]};
                    inst_cache = (pc_i[31:29] == 3'b100) && config_k0[0];
                end else if (w_hit) begin
                    w_can_req  = 1'b1;
                    inst_addr  = {w_hit_entry.pfn, pc_i[11:0]};
                    inst_cache = w_hit_entry.cattr[0];
                    w_tlb_exc  = w_hit_entry.miss || w_hit_entry.invalid;
                    w_sel_miss = w_hit_entry.miss;
                end
                if (valid_i && ready_i && !w_unmapped && !w_hit && !w_adel) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_next = ST_REQ;
            end
            ST_REQ: begin
                w_can_req  = 1'b1;
                inst_addr  = {w_rd_entry.pfn, r_pc_save[11:0]};
                inst_cache = w_rd_entry.cattr[0];
                w_tlb_exc  = w_rd_entry.miss || w_rd_entry.invalid;
                w_sel_miss = w_rd_entry.miss;
                if (inst_addr_ok) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (commit_i) begin
            w_next = ST_IDLE;
        end
    end

    // No translation result exists during LOOKUP, so it never raises an exception
    assign w_exc    = valid_i && (r_state != ST_LOOKUP) && (w_adel || w_tlb_exc);
    assign inst_req = valid_i && !w_exc && w_can_req;
    assign ready_o  = ready_i && (inst_addr_ok || w_exc);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the fetch PC while idle and remember which slot the refill used
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc_save  <= '0;
            r_fill_idx <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_pc_save <= pc_i;
            end
            if (r_state == ST_LOOKUP) begin
                r_fill_idx <= w_fill_idx;
            end
        end
    end

    // Stage output registers; refill flag only applies to TLB exceptions
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_o     <= 1'b0;
            pc_o        <= '0;
            cancelled_o <= 1'b0;
            exc_o       <= 1'b0;
            exc_miss_o  <= 1'b0;
            exccode_o   <= '0;
        end else if (ready_i) begin
            valid_o     <= (valid_i && inst_addr_ok) || w_exc;
            pc_o        <= w_cur_pc;
            cancelled_o <= commit_i;
            exc_o       <= w_exc;
            exc_miss_o  <= w_exc && !w_adel && w_sel_miss;
            exccode_o   <= w_adel ? EXC_ADEL : EXC_TLBL;
        end
    end

    // Performance counters (free-running, wrap naturally)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_utlb_miss <= '0;
            perf_waitreq   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (w_next == ST_LOOKUP)) begin
                perf_utlb_miss <= perf_utlb_miss + 1'b1;
            end
            if (inst_req && !inst_addr_ok) begin
                perf_waitreq <= perf_waitreq + 1'b1;
            end
        end
    end

    // Bits of these buses that the stage does not consume
    assign w_unused = &{1'b0, status, config_k0[2:1], tlb_paddr[11:0],
                        w_hit_entry.vpn, w_rd_entry.vpn};

endmodule
`default_nettype wire

// File: tb/tb_ifetch_utlb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_utlb
// Description : Self-checking bench for ifetch_utlb: directed scenarios with
//               literal expectations plus randomized traffic against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_utlb;

    localparam int ENTRIES = 2;
    localparam int PW      = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          valid_i = 1'b0, ready_i = 1'b0, inst_addr_ok = 1'b0;
    logic [31:0]   pc_i = '0;
    logic          ready_o, inst_req, inst_cache;
    logic [31:0]   inst_addr, tlb_vaddr;
    logic [31:0]   tlb_paddr = '0;
    logic          tlb_miss = 1'b0, tlb_invalid = 1'b0;
    logic [2:0]    tlb_cattr = 3'b011;
    logic          tlb_write = 1'b0, commit_i = 1'b0;
    logic [31:0]   status = '0;
    logic [2:0]    config_k0 = 3'b011;
    logic          valid_o, cancelled_o, exc_o, exc_miss_o, ok_to_branch;
    logic [31:0]   pc_o;
    logic [4:0]    exccode_o;
    logic [PW-1:0] perf_utlb_miss, perf_waitreq;

    always #5 clk = ~clk;

    ifetch_utlb #(
        .UTLB_ENTRIES (ENTRIES),
        .PERF_WIDTH   (PW)
    ) dut (
        .clk (clk), .resetn (resetn),
        .valid_i (valid_i), .pc_i (pc_i), .ready_i (ready_i), .ready_o (ready_o),
        .inst_req (inst_req), .inst_cache (inst_cache), .inst_addr (inst_addr),
        .inst_addr_ok (inst_addr_ok), .tlb_vaddr (tlb_vaddr), .tlb_paddr (tlb_paddr),
        .tlb_miss (tlb_miss), .tlb_invalid (tlb_invalid), .tlb_cattr (tlb_cattr),
        .tlb_write (tlb_write), .commit_i (commit_i), .status (status),
        .config_k0 (config_k0), .valid_o (valid_o), .pc_o (pc_o),
        .cancelled_o (cancelled_o), .exc_o (exc_o), .exc_miss_o (exc_miss_o),
        .exccode_o (exccode_o), .ok_to_branch (ok_to_branch),
        .perf_utlb_miss (perf_utlb_miss), .perf_waitreq (perf_waitreq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit        v;
        bit [19:0] vpn;
        bit [19:0] pfn;
        bit        miss;
        bit        inv;
        bit [2:0]  ca;
    } ment_t;

    ment_t     mt [ENTRIES];
    ment_t     m_cur;                 // result fetched from the main TLB for the walk in flight
    int        m_rr = 0;
    int        m_phase = 0;           // 0 idle, 1 walking main TLB, 2 issuing refilled request
    bit [31:0] m_pcs = '0;
    bit        m_valid_o, m_canc, m_exc, m_emiss;
    bit [4:0]  m_code;
    bit [31:0] m_pco, m_pmiss, m_pwait;
    bit        m_init = 1'b0;

    initial begin : p_cmp
        bit s_rst, s_v, s_rdy, s_ok, s_tw, s_cm, s_miss, s_inv;
        bit [31:0] s_pc, s_st, s_pa;
        bit [2:0]  s_k0, s_ca;
        bit [31:0] pc, eaddr;
        bit user, adel, hit, can, tlbexc, smiss, ecache, exc, ereq, erdy, full, clr;
        ment_t he;
        int nxt, tgt;
        forever begin
            @(negedge clk);
            s_rst = resetn; s_v = valid_i; s_pc = pc_i; s_rdy = ready_i; s_ok = inst_addr_ok;
            s_st = status; s_k0 = config_k0; s_pa = tlb_paddr; s_miss = tlb_miss;
            s_inv = tlb_invalid; s_ca = tlb_cattr; s_tw = tlb_write; s_cm = commit_i;

            pc   = (m_phase == 0) ? s_pc : m_pcs;
            user = s_st[4] && !s_st[1];
            adel = (pc[1:0] != 2'b00) || (pc[31] && user);
            hit  = 1'b0;
            he   = '0;
            foreach (mt[i]) if (mt[i].v && mt[i].vpn == s_pc[31:12]) begin hit = 1'b1; he = mt[i]; end
            can = 0; tlbexc = 0; smiss = 0; eaddr = 0; ecache = 0;
            if (m_phase == 0) begin
                if (s_pc[31:30] == 2'b10) begin
                    can = 1; eaddr = s_pc & 32'h1FFF_FFFF;
                    ecache = (s_pc[31:29] == 3'b100) && s_k0[0];
                end else if (hit) begin
                    can = 1; eaddr = {he.pfn, s_pc[11:0]}; ecache = he.ca[0];
                    tlbexc = he.miss || he.inv; smiss = he.miss;
                end
            end else if (m_phase == 2) begin
                can = 1; eaddr = {m_cur.pfn, m_pcs[11:0]}; ecache = m_cur.ca[0];
                tlbexc = m_cur.miss || m_cur.inv; smiss = m_cur.miss;
            end
            exc  = s_v && (m_phase != 1) && (adel || tlbexc);
            ereq = s_v && !exc && can;
            erdy = s_rdy && (s_ok || exc);

            if (m_init) begin
                chk("ready_o", 32'(ready_o), 32'(erdy));
                chk("inst_req", 32'(inst_req), 32'(ereq));
                if (ereq) begin
                    chk("inst_addr", inst_addr, eaddr);
                    chk("inst_cache", 32'(inst_cache), 32'(ecache));
                end
                chk("tlb_vaddr", tlb_vaddr, m_pcs);
                chk("ok_to_branch", 32'(ok_to_branch), 32'(m_phase == 0));
                chk("valid_o", 32'(valid_o), 32'(m_valid_o));
                chk("pc_o", pc_o, m_pco);
                chk("cancelled_o", 32'(cancelled_o), 32'(m_canc));
                chk("exc_o", 32'(exc_o), 32'(m_exc));
                chk("exc_miss_o", 32'(exc_miss_o), 32'(m_emiss));
                chk("exccode_o", 32'(exccode_o), 32'(m_code));
                chk("perf_utlb_miss", perf_utlb_miss, m_pmiss);
                chk("perf_waitreq", perf_waitreq, m_pwait);
            end

            @(posedge clk);
            if (!s_rst) begin
                foreach (mt[i]) mt[i].v = 1'b0;
                m_rr = 0; m_phase = 0; m_pcs = 0;
                m_valid_o = 0; m_canc = 0; m_exc = 0; m_emiss = 0; m_code = 0; m_pco = 0;
                m_pmiss = 0; m_pwait = 0; m_init = 1'b1;
            end else begin
                clr = s_tw || s_cm;
                nxt = m_phase;
                if (m_phase == 0 && s_v && s_rdy && s_pc[31:30] != 2'b10 && !hit && !adel) nxt = 1;
                else if (m_phase == 1) nxt = 2;
                else if (m_phase == 2 && s_ok) nxt = 0;
                if (s_cm) nxt = 0;
                if (m_phase == 0 && nxt == 1) m_pmiss++;
                if (m_phase == 1) begin
                    tgt = -1;
                    foreach (mt[i]) if (!mt[i].v && tgt < 0) tgt = i;
                    full = (tgt < 0);
                    if (full) tgt = m_rr;
                    m_cur = '{v: !clr, vpn: m_pcs[31:12], pfn: s_pa[31:12],
                              miss: s_miss, inv: s_inv, ca: s_ca};
                    mt[tgt] = m_cur;
                    if (!clr && full) m_rr = (m_rr + 1) % ENTRIES;
                end
                if (clr) foreach (mt[i]) mt[i].v = 1'b0;
                if (s_rdy) begin
                    m_valid_o = (s_v && s_ok) || exc;
                    m_pco     = pc;
                    m_canc    = s_cm;
                    m_exc     = exc;
                    m_emiss   = exc && !adel && smiss;
                    m_code    = adel ? 5'h04 : 5'h02;
                end
                if (ereq && !s_ok) m_pwait++;
                if (m_phase == 0) m_pcs = s_pc;
                m_phase = nxt;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input bit v, input bit [31:0] pc, input bit rdy, input bit ok);
        valid_i = v; pc_i = pc; ready_i = rdy; inst_addr_ok = ok;
    endtask

    // Miss, walk and complete a refill of one page
    task automatic fill(input bit [31:0] pc, input bit [31:0] pa);
        tlb_paddr = pa;
        setin(1, pc, 1, 0); tick();
        setin(1, pc, 1, 0); tick();
        setin(1, pc, 1, 1); tick();
        setin(0, 32'h0, 1, 0);
    endtask

    bit [19:0] pages [8] = '{20'h00001, 20'h00002, 20'h00003, 20'h00400,
                            20'h7FFFF, 20'h80000, 20'hA0000, 20'hC0000};

    initial begin : p_main
        bit [31:0] rpc;
        repeat (3) tick();
        resetn = 1'b1;

        // reset state
        setin(0, 32'h0, 1, 0);
        @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 0);
        chk("rst_pc_o", pc_o, 0);
        chk("rst_exccode", 32'(exccode_o), 0);
        chk("rst_perf_miss", perf_utlb_miss, 0);
        chk("rst_ok_to_branch", 32'(ok_to_branch), 1);
        tick();

        // kseg1 boot fetch, then kseg0 cacheable fetch
        setin(1, 32'hBFC0_0000, 1, 1);
        @(negedge clk);
        chk("k1_req", 32'(inst_req), 1);
        chk("k1_addr", inst_addr, 32'h1FC0_0000);
        chk("k1_cache", 32'(inst_cache), 0);
        chk("k1_ready", 32'(ready_o), 1);
        tick();
        setin(1, 32'h8000_1000, 1, 1);
        @(negedge clk);
        chk("k1_valid_o", 32'(valid_o), 1);
        chk("k1_pc_o", pc_o, 32'hBFC0_0000);
        chk("k0_addr", inst_addr, 32'h0000_1000);
        chk("k0_cache", 32'(inst_cache), 1);
        tick();

        // cold mapped fetch walks IDLE, LOOKUP, REQ
        tlb_paddr = 32'h0123_4000;
        setin(1, 32'h0040_0000, 1, 0);
        @(negedge clk);
        chk("cold_no_req", 32'(inst_req), 0);
        tick();
        @(negedge clk);
        chk("lookup_vaddr", tlb_vaddr, 32'h0040_0000);
        chk("lookup_not_idle", 32'(ok_to_branch), 0);
        tick();
        setin(1, 32'h0040_0000, 1, 1);
        @(negedge clk);
        chk("req_req", 32'(inst_req), 1);
        chk("req_addr", inst_addr, 32'h0123_4000);
        tick();
        setin(1, 32'h0040_0004, 1, 1);
        @(negedge clk);
        chk("hit_idle", 32'(ok_to_branch), 1);
        chk("hit_req", 32'(inst_req), 1);
        chk("hit_addr", inst_addr, 32'h0123_4004);
        tick();
        setin(0, 32'h0, 1, 0);
        @(negedge clk);
        chk("one_lookup", perf_utlb_miss, 1);
        chk("model_pmiss", m_pmiss, 1);
        tick();

        // two-entry replacement
        tlb_write = 1'b1; tick(); tlb_write = 1'b0;
        fill(32'h0000_1000, 32'h0A00_0000);
        fill(32'h0000_2000, 32'h0B00_0000);
        fill(32'h0000_3000, 32'h0C00_0000);
        chk("model_rr", 32'(m_rr), 1);
        setin(1, 32'h0000_1000, 0, 1);
        @(negedge clk);
        chk("evicted_1000", 32'(inst_req), 0);
        tick();
        setin(1, 32'h0000_2000, 0, 1);
        @(negedge clk);
        chk("kept_2000", 32'(inst_req), 1);
        chk("kept_2000_addr", inst_addr, 32'h0B00_0000);
        tick();
        setin(1, 32'h0000_3000, 0, 1);
        @(negedge clk);
        chk("new_3000_addr", inst_addr, 32'h0C00_0000);
        chk("four_lookups", perf_utlb_miss, 4);
        tick();

        // refill exception, then commit out of REQ
        tlb_miss = 1'b1; tlb_paddr = 32'h0;
        setin(1, 32'h0080_0000, 1, 0); tick();
        tick();
        @(negedge clk);
        chk("tlbl_no_req", 32'(inst_req), 0);
        chk("tlbl_ready", 32'(ready_o), 1);
        tick();
        commit_i = 1'b1;
        @(negedge clk);
        chk("tlbl_exc", 32'(exc_o), 1);
        chk("tlbl_miss", 32'(exc_miss_o), 1);
        chk("tlbl_code", 32'(exccode_o), 32'h02);
        tick();
        commit_i = 1'b0; tlb_miss = 1'b0;
        setin(0, 32'h0, 1, 0);
        @(negedge clk);
        chk("commit_cancel", 32'(cancelled_o), 1);
        chk("commit_idle", 32'(ok_to_branch), 1);
        tick();

        // address errors: misaligned, and kernel address from user mode
        setin(1, 32'h0040_0002, 1, 0); tick();
        setin(0, 32'h0, 1, 0);
        @(negedge clk);
        chk("adel_exc", 32'(exc_o), 1);
        chk("adel_code", 32'(exccode_o), 32'h04);
        chk("adel_no_walk", 32'(ok_to_branch), 1);
        tick();
        status = 32'h0000_0010;
        setin(1, 32'h8000_0000, 1, 0); tick();
        status = 32'h0;
        setin(0, 32'h0, 1, 0);
        @(negedge clk);
        chk("user_adel_code", 32'(exccode_o), 32'h04);
        tick();

        // main-TLB write during the walk leaves nothing valid
        tlb_paddr = 32'h0D00_0000;
        setin(1, 32'h0000_5000, 1, 0); tick();
        tlb_write = 1'b1; tick(); tlb_write = 1'b0;
        setin(1, 32'h0000_5000, 1, 1); tick();
        setin(1, 32'h0000_5000, 0, 0);
        @(negedge clk);
        chk("flushed_fill", 32'(inst_req), 0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rpc = {pages[$urandom_range(0, 7)], 12'($urandom_range(0, 4095)) & 12'hFFC};
            if ($urandom_range(0, 15) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            setin($urandom_range(0, 9) != 0, rpc, $urandom_range(0, 4) != 0, $urandom_range(0, 4) < 3);
            status      = ($urandom_range(0, 7) == 0) ? 32'h0000_0010 :
                          (($urandom_range(0, 7) == 0) ? 32'h0000_0012 : 32'h0);
            config_k0   = 3'($urandom_range(0, 7));
            tlb_paddr   = $urandom;
            tlb_miss    = ($urandom_range(0, 7) == 0);
            tlb_invalid = ($urandom_range(0, 7) == 0);
            tlb_cattr   = 3'($urandom_range(0, 7));
            tlb_write   = ($urandom_range(0, 31) == 0);
            commit_i    = ($urandom_range(0, 31) == 0);
            resetn      = ($urandom_range(0, 199) != 0);
            tick();
        end
        resetn = 1'b1; tlb_write = 1'b0; commit_i = 1'b0;
        setin(0, 32'h0, 1, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
